// File: rtl/dense_ser_pkg.sv
// Shared types and constants for dense_cmd_serializer.
// DENSE_SER_CHECKSUM_EN adds the TRAILER state.
package dense_ser_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HEADER,
    ST_FLAGS,
    ST_IDX,
    ST_W,
    ST_X,
    ST_LABEL
`ifdef DENSE_SER_CHECKSUM_EN
    ,
    ST_TRAILER
`endif
  } dense_ser_state_t;

  localparam int unsigned FLAG_IS_UPDATE     = 0;
  localparam int unsigned FLAG_LOAD_W        = 1;
  localparam int unsigned FLAG_BACKPROP_COST = 2;
  localparam int unsigned FLAG_IS_COST_LAYER = 3;

  localparam int unsigned IDX_WORDS = 4;

  // Header word is {cost_type, dense_type, act_type} packed from bit 0 upward.
  localparam int unsigned HDR_ACT_LSB = 0;

  function automatic int unsigned hdr_dense_lsb(input int unsigned act_w);
    return HDR_ACT_LSB + act_w;
  endfunction

  function automatic int unsigned hdr_cost_lsb(input int unsigned act_w,
                                               input int unsigned dense_w);
    return HDR_ACT_LSB + act_w + dense_w;
  endfunction

endpackage

// File: rtl/dense_cmd_serializer.sv
// Captures one dense command and streams it as data_size-bit words.
// Define DENSE_SER_CHECKSUM_EN to append an XOR trailer word.
module dense_cmd_serializer
  import dense_ser_pkg::*;
#(
  parameter int unsigned size            = 3,
  parameter int unsigned data_size       = 16,
  parameter int unsigned cost_type_size  = 8,
  parameter int unsigned dense_type_size = 4,
  parameter int unsigned act_type_size   = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [act_type_size-1:0]    act_type,
  input  logic [dense_type_size-1:0]  dense_type,
  input  logic [cost_type_size-1:0]   cost_type,
  input  logic [data_size*size-1:0]   w,
  input  logic [data_size*size-1:0]   x,
  input  logic [data_size*size-1:0]   label_in,
  input  logic [31:0]                 w_layer_index,
  input  logic [31:0]                 w_row_index,
  input  logic                        is_update,
  input  logic                        load_w,
  input  logic                        backprop_cost,
  input  logic                        is_cost_layer,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [data_size-1:0]        out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_last
);

  localparam int unsigned CNT_MAX   = (size > IDX_WORDS) ? size : IDX_WORDS;
  localparam int unsigned CNT_W     = $clog2(CNT_MAX);
  localparam int unsigned DENSE_LSB = hdr_dense_lsb(act_type_size);
  localparam int unsigned COST_LSB  = hdr_cost_lsb(act_type_size, dense_type_size);
  localparam logic [CNT_W-1:0] LAST_ELEM = CNT_W'(size - 1);
  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(IDX_WORDS - 1);

  typedef logic [data_size-1:0] word_t;

  dense_ser_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [act_type_size-1:0]   act_q, act_d;
  logic [dense_type_size-1:0] dense_q, dense_d;
  logic [cost_type_size-1:0]  cost_q, cost_d;
  word_t w_q [size];
  word_t w_d [size];
  word_t x_q [size];
  word_t x_d [size];
  word_t lbl_q [size];
  word_t lbl_d [size];
  logic [31:0] layer_q, layer_d;
  logic [31:0] row_q, row_d;
  logic is_update_q, is_update_d;
  logic load_w_q, load_w_d;
  logic backprop_q, backprop_d;
  logic is_cost_q, is_cost_d;

  logic  in_ready_q, in_ready_d;
  word_t out_data_q, out_data_d;
  logic  out_valid_q, out_valid_d;
  logic  out_last_q, out_last_d;
  logic  accept;
  dense_ser_state_t end_state;

`ifdef DENSE_SER_CHECKSUM_EN
  word_t csum_q, csum_d;
  assign end_state = ST_TRAILER;
`else
  assign end_state = ST_IDLE;
`endif

  assign accept = out_valid_q && out_ready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    act_d       = act_q;
    dense_d     = dense_q;
    cost_d      = cost_q;
    w_d         = w_q;
    x_d         = x_q;
    lbl_d       = lbl_q;
    layer_d     = layer_q;
    row_d       = row_q;
    is_update_d = is_update_q;
    load_w_d    = load_w_q;
    backprop_d  = backprop_q;
    is_cost_d   = is_cost_q;
`ifdef DENSE_SER_CHECKSUM_EN
    csum_d      = csum_q;
`endif

    if (state_q == ST_IDLE) begin
      if (in_valid && in_ready_q) begin
        act_d       = act_type;
        dense_d     = dense_type;
        cost_d      = cost_type;
        for (int unsigned i = 0; i < size; i++) begin
          w_d[i]   = w[i*data_size +: data_size];
          x_d[i]   = x[i*data_size +: data_size];
          lbl_d[i] = label_in[i*data_size +: data_size];
        end
        layer_d     = w_layer_index;
        row_d       = w_row_index;
        is_update_d = is_update;
        load_w_d    = load_w;
        backprop_d  = backprop_cost;
        is_cost_d   = is_cost_layer;
        cnt_d       = '0;
        state_d     = ST_HEADER;
`ifdef DENSE_SER_CHECKSUM_EN
        csum_d      = '0;
`endif
      end
    end else if (accept) begin
`ifdef DENSE_SER_CHECKSUM_EN
      csum_d = csum_q ^ out_data_q;
`endif
      case (state_q)
        ST_HEADER: state_d = ST_FLAGS;
        ST_FLAGS: begin
          state_d = ST_IDX;
          cnt_d   = '0;
        end
        ST_IDX: begin
          if (cnt_q == LAST_IDX) begin
            cnt_d   = '0;
            state_d = load_w_q ? ST_W : ST_X;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_W: begin
          if (cnt_q == LAST_ELEM) begin
            cnt_d   = '0;
            state_d = ST_X;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_X: begin
          if (cnt_q == LAST_ELEM) begin
            cnt_d   = '0;
            state_d = is_cost_q ? ST_LABEL : end_state;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_LABEL: begin
          if (cnt_q == LAST_ELEM) begin
            cnt_d   = '0;
            state_d = end_state;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Outputs are built from the next state so they register alongside it.
  always_comb begin
    out_data_d  = '0;
    out_last_d  = 1'b0;
    out_valid_d = (state_d != ST_IDLE);
    in_ready_d  = (state_d == ST_IDLE);
    case (state_d)
      ST_HEADER: begin
        out_data_d[HDR_ACT_LSB +: act_type_size]  = act_d;
        out_data_d[DENSE_LSB +: dense_type_size]  = dense_d;
        out_data_d[COST_LSB +: cost_type_size]    = cost_d;
      end
      ST_FLAGS: begin
        out_data_d[FLAG_IS_UPDATE]     = is_update_d;
        out_data_d[FLAG_LOAD_W]        = load_w_d;
        out_data_d[FLAG_BACKPROP_COST] = backprop_d;
        out_data_d[FLAG_IS_COST_LAYER] = is_cost_d;
      end
      ST_IDX: begin
        case (cnt_d)
          CNT_W'(0): out_data_d[15:0] = layer_d[15:0];
          CNT_W'(1): out_data_d[15:0] = layer_d[31:16];
          CNT_W'(2): out_data_d[15:0] = row_d[15:0];
          default:   out_data_d[15:0] = row_d[31:16];
        endcase
      end
      ST_W: out_data_d = w_d[cnt_d];
      ST_X: begin
        out_data_d = x_d[cnt_d];
`ifndef DENSE_SER_CHECKSUM_EN
        out_last_d = (cnt_d == LAST_ELEM) && !is_cost_d;
`endif
      end
      ST_LABEL: begin
        out_data_d = lbl_d[cnt_d];
`ifndef DENSE_SER_CHECKSUM_EN
        out_last_d = (cnt_d == LAST_ELEM);
`endif
      end
`ifdef DENSE_SER_CHECKSUM_EN
      ST_TRAILER: begin
        out_data_d = csum_d;
        out_last_d = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      act_q       <= '0;
      dense_q     <= '0;
      cost_q      <= '0;
      w_q         <= '{default: '0};
      x_q         <= '{default: '0};
      lbl_q       <= '{default: '0};
      layer_q     <= '0;
      row_q       <= '0;
      is_update_q <= 1'b0;
      load_w_q    <= 1'b0;
      backprop_q  <= 1'b0;
      is_cost_q   <= 1'b0;
      in_ready_q  <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
`ifdef DENSE_SER_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      act_q       <= act_d;
      dense_q     <= dense_d;
      cost_q      <= cost_d;
      w_q         <= w_d;
      x_q         <= x_d;
      lbl_q       <= lbl_d;
      layer_q     <= layer_d;
      row_q       <= row_d;
      is_update_q <= is_update_d;
      load_w_q    <= load_w_d;
      backprop_q  <= backprop_d;
      is_cost_q   <= is_cost_d;
      in_ready_q  <= in_ready_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
`ifdef DENSE_SER_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_dense_cmd_serializer.sv
// Directed bench for dense_cmd_serializer; follows DENSE_SER_CHECKSUM_EN when defined.
module tb_dense_cmd_serializer;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  act_type;
  logic [3:0]  dense_type;
  logic [7:0]  cost_type;
  logic [47:0] w, x, label_in;
  logic [31:0] w_layer_index, w_row_index;
  logic        is_update, load_w, backprop_cost, is_cost_layer;
  logic        in_valid, in_ready;
  logic [15:0] out_data;
  logic        out_valid, out_ready, out_last;

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] exp_w [0:15];
  int exp_n;

  always #5 clk = ~clk;

  dense_cmd_serializer #(
    .size(3), .data_size(16), .cost_type_size(8),
    .dense_type_size(4), .act_type_size(4)
  ) dut (
    .clk(clk), .reset(reset),
    .act_type(act_type), .dense_type(dense_type), .cost_type(cost_type),
    .w(w), .x(x), .label_in(label_in),
    .w_layer_index(w_layer_index), .w_row_index(w_row_index),
    .is_update(is_update), .load_w(load_w),
    .backprop_cost(backprop_cost), .is_cost_layer(is_cost_layer),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // c2=0: plain command; c2=1: W and LABEL sections enabled
  task automatic set_fields(input bit c2);
    act_type      = 4'h1;
    dense_type    = 4'h2;
    cost_type     = 8'h34;
    x             = {16'h0003, 16'h0002, 16'h0001};
    w             = c2 ? {16'h000C, 16'h000B, 16'h000A} : 48'h0;
    label_in      = c2 ? {16'h0009, 16'h0008, 16'h0007} : 48'h0;
    w_layer_index = 32'h0001_0002;
    w_row_index   = 32'h0000_0005;
    is_update     = 1'b0;
    backprop_cost = 1'b0;
    load_w        = c2;
    is_cost_layer = c2;
  endtask

  task automatic set_exp(input bit c2);
    logic [15:0] acc;
    if (!c2) begin
      exp_w[0] = 16'h3421; exp_w[1] = 16'h0000;
      exp_w[2] = 16'h0002; exp_w[3] = 16'h0001; exp_w[4] = 16'h0005; exp_w[5] = 16'h0000;
      exp_w[6] = 16'h0001; exp_w[7] = 16'h0002; exp_w[8] = 16'h0003;
      exp_n = 9;
    end else begin
      exp_w[0]  = 16'h3421; exp_w[1]  = 16'h000A;
      exp_w[2]  = 16'h0002; exp_w[3]  = 16'h0001; exp_w[4]  = 16'h0005; exp_w[5]  = 16'h0000;
      exp_w[6]  = 16'h000A; exp_w[7]  = 16'h000B; exp_w[8]  = 16'h000C;
      exp_w[9]  = 16'h0001; exp_w[10] = 16'h0002; exp_w[11] = 16'h0003;
      exp_w[12] = 16'h0007; exp_w[13] = 16'h0008; exp_w[14] = 16'h0009;
      exp_n = 15;
    end
    acc = '0;
    for (int i = 0; i < exp_n; i++) acc = acc ^ exp_w[i];
`ifdef DENSE_SER_CHECKSUM_EN
    exp_w[exp_n] = acc;
    exp_n = exp_n + 1;
`endif
  endtask

  // Accept n_stop words starting in the current cycle, checking order, last and stall stability.
  task automatic collect(input int n_stop, input bit toggle);
    int k = 0;
    int cyc = 0;
    bit stall = 1'b0;
    logic [15:0] pd = '0;
    logic pl = 1'b0;
    while (k < n_stop && cyc < 400) begin
      out_ready = toggle ? cyc[0] : 1'b1;
      chk("in_ready_busy", {31'b0, in_ready}, 32'd0);
      if (stall) begin
        chk("stall_data", {16'b0, out_data}, {16'b0, pd});
        chk("stall_valid", {31'b0, out_valid}, 32'd1);
        chk("stall_last", {31'b0, out_last}, {31'b0, pl});
      end
      if (out_valid && out_ready) begin
        chk($sformatf("word%0d", k), {16'b0, out_data}, {16'b0, exp_w[k]});
        chk($sformatf("last%0d", k), {31'b0, out_last}, {31'b0, (k == exp_n - 1)});
        k++;
      end
      stall = out_valid && !out_ready;
      pd = out_data;
      pl = out_last;
      tick();
      cyc++;
    end
    chk("words_accepted", k, n_stop);
    out_ready = 1'b1;
  endtask

  task automatic post_frame();
    chk("post_valid", {31'b0, out_valid}, 32'd0);
    chk("post_in_ready", {31'b0, in_ready}, 32'd1);
  endtask

  task automatic send_one(input bit c2, input bit toggle);
    set_fields(c2);
    set_exp(c2);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("first_valid", {31'b0, out_valid}, 32'd1);
    chk("first_in_ready", {31'b0, in_ready}, 32'd0);
    collect(exp_n, toggle);
    post_frame();
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    set_fields(1'b0);
    tick();
    tick();
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_last", {31'b0, out_last}, 32'd0);
    chk("rst_data", {16'b0, out_data}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    reset = 1'b0;
    tick();
    chk("rel_in_ready", {31'b0, in_ready}, 32'd1);
    tick();
    chk("idle_ready_no_effect", {31'b0, out_valid}, 32'd0);

    // Minimal frame, then full frame, then full frame under backpressure
    send_one(1'b0, 1'b0);
    send_one(1'b1, 1'b0);
    send_one(1'b1, 1'b1);

    // Back-to-back: inputs change mid-frame and must not leak into frame 1
    set_fields(1'b0);
    set_exp(1'b0);
    in_valid = 1'b1;
    tick();
    chk("b2b_first_valid", {31'b0, out_valid}, 32'd1);
    set_fields(1'b1);
    collect(exp_n, 1'b0);
    post_frame();
    tick();
    in_valid = 1'b0;
    set_exp(1'b1);
    chk("b2b_second_valid", {31'b0, out_valid}, 32'd1);
    collect(exp_n, 1'b0);
    post_frame();

    // Reset after five accepted words
    set_fields(1'b0);
    set_exp(1'b0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    collect(5, 1'b0);
    reset = 1'b1;
    tick();
    chk("midrst_valid", {31'b0, out_valid}, 32'd0);
    chk("midrst_last", {31'b0, out_last}, 32'd0);
    chk("midrst_data", {16'b0, out_data}, 32'd0);
    chk("midrst_in_ready", {31'b0, in_ready}, 32'd0);
    reset = 1'b0;
    tick();
    chk("midrst_rel_ready", {31'b0, in_ready}, 32'd1);
    chk("midrst_rel_valid", {31'b0, out_valid}, 32'd0);
    send_one(1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dense_cmd_serializer.md
# dense_cmd_serializer

Transmit-side counterpart of the dense-layer decode register stage. It captures one complete dense command (parse code, indices, control flags, weight/input/label vectors) through a valid/ready handshake and emits it as an ordered stream of `data_size`-bit words for the command link. Words are sent one per accepted output beat. Its stream is the format the link receiver decodes back into the per-field buses that feed the decode register.

## Interface
- `size`, 3: elements per vector (w, x, label).
- `data_size`, 16: bits per element and per output word; must be ≥ 16.
- `cost_type_size`, 8: cost_type width.
- `dense_type_size`, 4: dense_type width.
- `act_type_size`, 4: act_type width; act + dense + cost widths must total ≤ 16.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `act_type`, `dense_type`, `cost_type` in param widths: parse-code fields.
- `w`, `x`, `label_in` in `data_size*size`: vectors; element i is bits `[i*data_size +: data_size]`.
- `w_layer_index`, `w_row_index` in 32: indices.
- `is_update`, `load_w`, `backprop_cost`, `is_cost_layer` in 1 each: control flags.
- `in_valid` in 1, `in_ready` out 1: command handshake.
- `out_data` out `data_size`: stream word.
- `out_valid` out 1, `out_ready` in 1, `out_last` out 1: stream handshake; `out_last` marks the final word.

## Operation
- States: IDLE, HEADER, FLAGS, IDX, W, X, LABEL, plus TRAILER when the macro is enabled.
- IDLE: `in_ready`=1. `in_valid && in_ready` registers every input field and moves to HEADER.
- Word order:
  - HEADER: `{cost_type, dense_type, act_type}` in the LSBs, zero-extended.
  - FLAGS: bits [3:0] = `{is_cost_layer, backprop_cost, load_w, is_update}`, rest zero.
  - IDX: four words in this order: layer[15:0], layer[31:16], row[15:0], row[31:16].
  - W: `size` words, only if captured `load_w`=1; otherwise skipped.
  - X: `size` words, always sent.
  - LABEL: `size` words, only if captured `is_cost_layer`=1; otherwise skipped.
- Within a section, elements go out in index order 0..size-1. A counter tracks position, resets at every section entry, and never wraps past `size-1`.
- The state advances only on `out_valid && out_ready`. After the last word is accepted, the block returns to IDLE.
- Frame length: 9 words (neither optional section), 12 (one optional section), 15 (both), each +1 with the trailer.
- Captured fields stay frozen for the whole frame. Input changes during a frame are ignored.

## Timing
- Reset values: `out_valid`=0, `out_last`=0, `out_data`=0, state=IDLE, counter=0. `in_ready`=0 while `reset` is high and 1 in the first cycle after.
- Latency: a capture at edge N gives HEADER with `out_valid`=1 after edge N. The first word is visible in the cycle following capture.
- Throughput: one word per cycle while `out_ready`=1.
- While `out_valid && !out_ready`, `out_data`, `out_valid` and `out_last` hold stable. `out_valid` never drops before acceptance.
- `in_ready`=0 from capture until the cycle after the final word is accepted. This leaves one idle bubble between back-to-back frames.
- Reset mid-frame: the frame is abandoned and the next cycle is IDLE with all outputs at reset values. No partial trailer is sent.
- `out_ready` may be high in IDLE; this has no effect.

## Configuration
- Macro `DENSE_SER_CHECKSUM_EN`.
  - Defined: a TRAILER word follows the last section. It carries the XOR of every preceding word of the frame, and `out_last` moves to it.
  - Undefined: no TRAILER state or accumulator, and `out_last` sits on the final X or LABEL word.

## Structure
- Package `dense_ser_pkg` holds:
  - state enum `dense_ser_state_t`;
  - flag bit positions (`FLAG_IS_UPDATE`=0, `FLAG_LOAD_W`=1, `FLAG_BACKPROP_COST`=2, `FLAG_IS_COST_LAYER`=3);
  - `IDX_WORDS`=4;
  - header field offsets.
- No sub-module. It is a single FSM with a capture register bank, a section counter and an optional XOR accumulator.

## Test plan
- size=3, `load_w`=0, `is_cost_layer`=0, x={1,2,3}, layer=0x00010002, row=5, `out_ready`=1 → 9 words: hdr, flags=0, 0x0002, 0x0001, 0x0005, 0x0000, 1, 2, 3, with `out_last` on word 3.
- `load_w`=1, `is_cost_layer`=1, w={A,B,C}, label={7,8,9} → 15 words, W before X before LABEL, flags=0xA, `out_last` only on 9.
- Toggle `out_ready` 0/1 every cycle during a 15-word frame → identical word sequence, and `out_data` stable during every stall cycle.
- Two commands with `in_valid` held high → second captured exactly one cycle after the first frame's last acceptance, with `in_ready`=0 throughout frame 1.
- Assert `reset` at word 5 → `out_valid`=0 next cycle, `in_ready`=1 one cycle after release; a new command yields a clean 9-word frame.
- With `DENSE_SER_CHECKSUM_EN`, case 1 → 10th word = XOR of the 9 words, `out_last` on it only.
